// File: rtl/uart_tx_byte_if.sv
// Byte-request / serial-line bundle between the byte-sender and the UART transmitter.
interface uart_tx_byte_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_en;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_en,
        output tx_data,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_byte.sv
// UART transmitter: shifts one accepted byte out LSB first as start/data/stop,
// then pulses tx_done and inserts a one-cycle gap before the next accept.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_byte_if.slave  tx_if
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Reject unsupported frame shapes at elaboration.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_byte: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_byte: DATA_BITS must be 5..8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_byte: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        GAP   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_serial_q, tx_serial_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 bit_end;

    assign bit_end = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // Next-state, bit timing and next-output decode.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_serial_d = 1'b1;
        tx_busy_d   = 1'b0;
        tx_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (tx_if.tx_en) begin
                    shift_d = tx_if.tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it once registered.
        case (state_d)
            START:   tx_serial_d = 1'b0;
            DATA:    tx_serial_d = shift_d[0];
            default: tx_serial_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
        tx_done_d = (state_d == DONE);
    end

    assign tx_if.tx_serial = tx_serial_q;
    assign tx_if.tx_busy   = tx_busy_q;
    assign tx_if.tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stop).
module tb_uart_tx_byte;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    uart_tx_byte_if #(.DATA_BITS(8)) if_a ();
    uart_tx_byte_if #(.DATA_BITS(8)) if_b ();

    uart_tx_byte #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tx_if (if_a)
    );

    uart_tx_byte #(.CLKS_PER_BIT(3), .DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tx_if (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ser(input int which);
        return (which == 1) ? if_b.tx_serial : if_a.tx_serial;
    endfunction

    function automatic logic busy(input int which);
        return (which == 1) ? if_b.tx_busy : if_a.tx_busy;
    endfunction

    function automatic logic done(input int which);
        return (which == 1) ? if_b.tx_done : if_a.tx_done;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected serial value k cycles into a frame (k=0 is the first START cycle).
    function automatic logic exp_line(input logic [7:0] d, input int k, input int cpb);
        int bitn;
        bitn = k / cpb;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return d[bitn-1];
        return 1'b1;
    endfunction

    // Called at the first START cycle; checks the whole frame and the DONE cycle,
    // returns at the GAP cycle. poke_k injects tx_en/tx_data noise on dut_a mid-frame.
    task automatic check_frame(input int which, input logic [7:0] d, input int cpb,
                               input int stops, input int poke_k);
        int total;
        total = (9 + stops) * cpb;
        for (int k = 0; k < total; k++) begin
            check("frame_serial", 32'(ser(which)), 32'(exp_line(d, k, cpb)));
            check("frame_busy", 32'(busy(which)), 32'd1);
            check("frame_done", 32'(done(which)), 32'd0);
            if (k == poke_k) begin
                if_a.tx_data = 8'hFF;
                if_a.tx_en   = 1'b1;
            end else if (k == poke_k + 1) begin
                if_a.tx_en = 1'b0;
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(done(which)), 32'd1);
        check("done_serial", 32'(ser(which)), 32'd1);
        check("done_busy", 32'(busy(which)), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_gap(input int which);
        check("gap_done", 32'(done(which)), 32'd0);
        check("gap_busy", 32'(busy(which)), 32'd1);
        check("gap_serial", 32'(ser(which)), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_idle(input int which, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_serial"}, 32'(ser(which)), 32'd1);
            check({tag, "_busy"}, 32'(busy(which)), 32'd0);
            check({tag, "_done"}, 32'(done(which)), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        if_a.tx_en   = 1'b0;
        if_a.tx_data = 8'h00;
        if_b.tx_en   = 1'b0;
        if_b.tx_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values and 100 idle cycles.
        check("rst_serial", 32'(if_a.tx_serial), 32'd1);
        check("rst_busy", 32'(if_a.tx_busy), 32'd0);
        check("rst_done", 32'(if_a.tx_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, 100, "idle_a");
        check_idle(1, 2, "idle_b");

        // Single byte 0xA5 from a one-cycle request.
        if_a.tx_en   = 1'b1;
        if_a.tx_data = 8'hA5;
        @(negedge clk);
        if_a.tx_en = 1'b0;
        check_frame(0, 8'hA5, 4, 1, -10);
        check_gap(0);
        check_idle(0, 10, "post_a5");

        // tx_en held high: 0x3C then 0xC3 back to back.
        if_a.tx_en   = 1'b1;
        if_a.tx_data = 8'h3C;
        @(negedge clk);
        check_frame(0, 8'h3C, 4, 1, -10);
        if_a.tx_data = 8'hC3;
        check_gap(0);
        check("b2b_idle_busy", 32'(if_a.tx_busy), 32'd0);
        check("b2b_idle_serial", 32'(if_a.tx_serial), 32'd1);
        @(negedge clk);
        check_frame(0, 8'hC3, 4, 1, -10);
        if_a.tx_en = 1'b0;
        check_gap(0);
        check_idle(0, 20, "post_b2b");

        // 0x00 frame with tx_data/tx_en disturbed during data bit 3.
        if_a.tx_en   = 1'b1;
        if_a.tx_data = 8'h00;
        @(negedge clk);
        if_a.tx_en = 1'b0;
        check_frame(0, 8'h00, 4, 1, 16);
        check_gap(0);
        check_idle(0, 20, "post_poke");

        // Reset in the middle of data bit 4 of 0x55.
        if_a.tx_en   = 1'b1;
        if_a.tx_data = 8'h55;
        @(negedge clk);
        if_a.tx_en = 1'b0;
        for (int k = 0; k < 22; k++) begin
            check("pre_rst_serial", 32'(if_a.tx_serial), 32'(exp_line(8'h55, k, 4)));
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("midrst_serial", 32'(if_a.tx_serial), 32'd1);
        check("midrst_busy", 32'(if_a.tx_busy), 32'd0);
        check("midrst_done", 32'(if_a.tx_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, 50, "post_rst");
        if_a.tx_en   = 1'b1;
        if_a.tx_data = 8'h81;
        @(negedge clk);
        if_a.tx_en = 1'b0;
        check_frame(0, 8'h81, 4, 1, -10);
        check_gap(0);
        check_idle(0, 5, "post_81");

        // Two stop bits at 3 clk/bit: 0xFF, tx_done 33 cycles after START.
        if_b.tx_en   = 1'b1;
        if_b.tx_data = 8'hFF;
        @(negedge clk);
        if_b.tx_en = 1'b0;
        check_frame(1, 8'hFF, 3, 2, -10);
        check_gap(1);
        check_idle(1, 10, "post_ff_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
